uart_rx_majority_sampler: RTL and testbench
===========================================

# uart_rx_majority_sampler

Parametrised oversampling bit sampler for the UART receiver. It captures a configurable odd number of RX samples centred on each bit period, as tracked by the external edge counter, and produces a majority-voted bit with a one-cycle valid strobe. It sits between the RX edge/bit counter and the RX FSM/deserializer. It adds capture-completeness checking and an optional noise flag.

## Interface
- `PRESC_W`, default 6: width of `prescaler` and `edge_cnt`.
- `VOTES`, default 3: samples per bit. Legal values are 3, 5 and 7; other values are an elaboration error.
- `clk` — in — 1 — RX oversampling clock.
- `rst` — in — 1 — asynchronous, active-low reset.
- `prescaler` — in — `PRESC_W` — oversampling ratio. Must be even and ≥ `VOTES`+1.
- `sample_en` — in — 1 — sampling enable, driven by the RX FSM.
- `edge_cnt` — in — `PRESC_W` — oversample index within the current bit, 0..`prescaler`-1.
- `rx_in` — in — 1 — serial RX line, already synchronised.
- `sampled_bit` — out — 1 — majority-voted bit.
- `sample_valid` — out — 1 — one-cycle strobe; `sampled_bit` is new this cycle.
- `noise_err` — out — 1 — votes were not unanimous. Present only with `UART_RX_NOISE_FLAG_EN`.

## Operation
- Window arithmetic is done in `PRESC_W`+1 bits, unsigned, with no wrap:
  - H = (V-1)/2
  - centre = (`prescaler`>>1) - 1
  - first = centre - H
  - last = centre + H
- Window indices are i = 0..V-1, at `edge_cnt` == first + i.
- If `prescaler` < V+1, the configuration is illegal. No captures occur and no `sample_valid` is produced.
- An odd `prescaler` is truncated by the shift; no error is raised.
- Internal state:
  - `votes[V-1:0]` holds the captured samples.
  - `got[V-1:0]` is the capture mask.
- While `sample_en`=1 and `edge_cnt` == first+i for i < V-1: set `votes[i]` ← `rx_in` and `got[i]` ← 1.
- While `sample_en`=1 and `edge_cnt` == last:
  - If all of `got[V-2:0]` are set, then on that same edge:
    - `sampled_bit` ← maj(`votes[V-2:0]`, `rx_in`)
    - `sample_valid` ← 1
  - If any `got` bit is missing (the counter skipped an index), then:
    - `sample_valid` stays 0
    - `sampled_bit` holds its value
  - In both cases, clear `votes` and `got` on that edge, ready for the next bit.
- maj = 1 iff popcount > H.
- `sample_en`=0, including a drop mid-window:
  - Clear `votes` and `got` next edge.
  - `sampled_bit` ← 0 and `sample_valid` ← 0.
  - No partial vote is ever emitted.
- `edge_cnt` wrapping to 0 while a window is partially captured: the stale mask is discarded at the next `last` (incomplete, so no valid). There is no carry-over between bits.
- A `prescaler` change while `sample_en`=1 is unsupported. The block stays safe (bounded by the mask check) but its output is undefined for that bit.

## Timing
- Reset values: `sampled_bit`=0, `sample_valid`=0, `noise_err`=0, `votes`=0, `got`=0.
- Latency: outputs are registered and visible the cycle after `edge_cnt` == last.
- `sample_valid` is high for exactly 1 cycle per complete window.
- `sampled_bit` holds until the next valid, or until `sample_en` deasserts.
- `sample_en` high for the entire window is required for a valid. `sample_en` sampled low on the `last` edge means no valid is produced.
- Asynchronous reset mid-window clears everything immediately. The first valid after reset requires a full new window.

## Configuration
- `UART_RX_NOISE_FLAG_EN` defined:
  - `noise_err` is registered with `sample_valid`.
  - It is 1 iff the V samples are not all equal.
  - It is 0 whenever `sample_valid` is 0.
- `UART_RX_NOISE_FLAG_EN` undefined:
  - The `noise_err` port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `uart_rx_pkg` holds:
  - `UART_MAX_VOTES` = 7.
  - `UART_PRESC_W_DEF` = 6.
  - The function computing window first/last from `prescaler` and V, shared with the RX FSM stop/parity checks.
- One natural sub-module, `majority_vote`:
  - Combinational popcount compare.
  - Parameter V; inputs `bits[V-1:0]`.
  - Outputs `maj` and `unanimous`.

## Test plan
- V=3, `prescaler`=8, `rx_in` sequence 1,0,1 at `edge_cnt` 2,3,4 → `sampled_bit`=1 and `sample_valid` pulse 1 cycle after `edge_cnt`=4; `noise_err`=1.
- V=5, `prescaler`=16, `rx_in`=0 throughout the window at `edge_cnt` 5..9 → `sampled_bit`=0, valid strobe, `noise_err`=0. Then `rx_in`=1,1,0,0,1 → `sampled_bit`=1.
- V=3, `prescaler`=8, `sample_en` dropped at `edge_cnt`=3 → no valid, `sampled_bit`=0 next cycle. Re-enable at `edge_cnt`=0 of the next bit → normal valid at `edge_cnt`=4+1.
- V=3, `prescaler`=8, `edge_cnt` jumps 1→3 (skips 2) → no valid, `sampled_bit` holds its previous value. The next bit with a full window yields a valid.
- V=3, `prescaler`=2 (illegal) → no valid over 20 bit periods. Switch to `prescaler`=4 while `sample_en`=0 → window at `edge_cnt` 0..2, valid produced.
- Reset asserted at `edge_cnt`=3 of an active window → all outputs 0 immediately. After release, the first valid appears only after a complete window.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: vote limits and the sampling-window calculation
// used by the majority sampler and the RX FSM stop/parity checks.
package uart_rx_pkg;

  localparam int UART_MAX_VOTES   = 7;
  localparam int UART_PRESC_W_DEF = 6;
  localparam int UART_WIN_W       = 16;

  typedef logic [UART_WIN_W-1:0] win_idx_t;

  typedef struct packed {
    logic     legal;
    win_idx_t first;
    win_idx_t last;
  } win_t;

  // Window centred on the bit; wider than any prescaler so nothing wraps once legal.
  function automatic win_t calc_window(input win_idx_t presc, input int votes);
    win_t     w;
    win_idx_t h;
    win_idx_t centre;
    h       = win_idx_t'((votes - 1) / 2);
    centre  = (presc >> 1) - win_idx_t'(1);
    w.legal = (presc >= win_idx_t'(votes + 1));
    w.first = centre - h;
    w.last  = centre + h;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_majority_sampler_majority_vote.sv
// Combinational majority and unanimity of V vote bits.
module majority_vote #(
  parameter int V = 3
) (
  input  logic [V-1:0] bits,
  output logic         maj,
  output logic         unanimous
);

  assign maj       = ($countones(bits) > ((V - 1) / 2));
  assign unanimous = (&bits) | ~(|bits);

endmodule

// File: rtl/uart_rx_majority_sampler.sv
// Oversampling bit sampler: captures VOTES samples centred in each bit and emits
// a majority-voted bit with a one-cycle strobe. UART_RX_NOISE_FLAG_EN adds noise_err.
module uart_rx_majority_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = UART_PRESC_W_DEF,
  parameter int VOTES   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic               sample_en,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic               rx_in,
  output logic               sampled_bit,
  output logic               sample_valid
`ifdef UART_RX_NOISE_FLAG_EN
  ,
  output logic               noise_err
`endif
);

  if (!(VOTES == 3 || VOTES == 5 || VOTES == 7) || VOTES > UART_MAX_VOTES ||
      PRESC_W >= UART_WIN_W) begin : g_bad_param
    $error("uart_rx_majority_sampler: VOTES must be 3, 5 or 7 and PRESC_W < %0d", UART_WIN_W);
  end

  win_t     win;
  win_idx_t edge_ext;
  logic     at_last;
  logic     maj;
  logic     unanimous;

  // The last sample is voted straight from rx_in, so only VOTES-1 are stored.
  logic [VOTES-2:0] votes;
  logic [VOTES-2:0] got;

  always_comb begin
    win      = calc_window(win_idx_t'(prescaler), VOTES);
    edge_ext = win_idx_t'(edge_cnt);
    at_last  = win.legal && (edge_ext == win.last);
  end

  majority_vote #(.V(VOTES)) u_vote (
    .bits      ({rx_in, votes}),
    .maj       (maj),
    .unanimous (unanimous)
  );

  // NOTE: sequential state uses non-blocking assignments only, and every register,
  // the small vote store included, is cleared by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      votes        <= '0;
      got          <= '0;
      sampled_bit  <= 1'b0;
      sample_valid <= 1'b0;
    end else if (!sample_en) begin
      votes        <= '0;
      got          <= '0;
      sampled_bit  <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (at_last) begin
        // A skipped index leaves a hole in the mask; such a bit is dropped silently.
        if (&got) begin
          sampled_bit  <= maj;
          sample_valid <= 1'b1;
        end
        votes <= '0;
        got   <= '0;
      end else if (win.legal) begin
        for (int i = 0; i < VOTES - 1; i++) begin
          if (edge_ext == win.first + win_idx_t'(i)) begin
            votes[i] <= rx_in;
            got[i]   <= 1'b1;
          end
        end
      end
    end
  end

`ifdef UART_RX_NOISE_FLAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      noise_err <= 1'b0;
    end else begin
      noise_err <= sample_en && at_last && (&got) && !unanimous;
    end
  end
`else
  logic unused_unanimous;
  assign unused_unanimous = unanimous;
`endif

endmodule

// File: tb/tb_uart_rx_majority_sampler.sv
// Scoreboard bench for uart_rx_majority_sampler: a V=3 and a V=5 instance,
// directed bits pushed as expectations and checked by per-instance monitors.
module tb_uart_rx_majority_sampler;

  typedef struct packed {
    logic b;
    logic n;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [5:0] presc_a, ec_a, presc_b, ec_b;
  logic       en_a, rx_a, en_b, rx_b;
  logic       sampled_bit_a, sample_valid_a, sampled_bit_b, sample_valid_b;
`ifdef UART_RX_NOISE_FLAG_EN
  logic       noise_a, noise_b;
`endif

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_majority_sampler #(.PRESC_W(6), .VOTES(3)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .prescaler    (presc_a),
    .sample_en    (en_a),
    .edge_cnt     (ec_a),
    .rx_in        (rx_a),
    .sampled_bit  (sampled_bit_a),
    .sample_valid (sample_valid_a)
`ifdef UART_RX_NOISE_FLAG_EN
    ,
    .noise_err    (noise_a)
`endif
  );

  uart_rx_majority_sampler #(.PRESC_W(6), .VOTES(5)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .prescaler    (presc_b),
    .sample_en    (en_b),
    .edge_cnt     (ec_b),
    .rx_in        (rx_b),
    .sampled_bit  (sampled_bit_b),
    .sample_valid (sample_valid_b)
`ifdef UART_RX_NOISE_FLAG_EN
    ,
    .noise_err    (noise_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && sample_valid_a) begin
      check("a_valid_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_bit", 32'(sampled_bit_a), 32'(e.b));
`ifdef UART_RX_NOISE_FLAG_EN
        check("a_noise", 32'(noise_a), 32'(e.n));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && sample_valid_b) begin
      check("b_valid_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_bit", 32'(sampled_bit_b), 32'(e.b));
`ifdef UART_RX_NOISE_FLAG_EN
        check("b_noise", 32'(noise_b), 32'(e.n));
`endif
      end
    end
  end

  task automatic a_cyc(input int e, input logic r, input logic en);
    ec_a = 6'(e);
    rx_a = r;
    en_a = en;
    @(posedge clk);
    #1;
  endtask

  task automatic b_cyc(input int e, input logic r, input logic en);
    ec_b = 6'(e);
    rx_b = r;
    en_b = en;
    @(posedge clk);
    #1;
  endtask

  // One full bit period; rxv[e] is the line value at edge_cnt e.
  task automatic a_bit(input logic [15:0] rxv, input int presc);
    for (int e = 0; e < presc; e++) a_cyc(e, rxv[e], 1'b1);
  endtask

  task automatic b_bit(input logic [15:0] rxv, input int presc);
    for (int e = 0; e < presc; e++) b_cyc(e, rxv[e], 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    presc_a = 6'd8;  ec_a = '0; en_a = 1'b0; rx_a = 1'b0;
    presc_b = 6'd16; ec_b = '0; en_b = 1'b0; rx_b = 1'b0;
    #3;
    check("reset_bit_a",   32'(sampled_bit_a),  32'd0);
    check("reset_valid_a", 32'(sample_valid_a), 32'd0);
    check("reset_bit_b",   32'(sampled_bit_b),  32'd0);
    check("reset_valid_b", 32'(sample_valid_b), 32'd0);
`ifdef UART_RX_NOISE_FLAG_EN
    check("reset_noise_a", 32'(noise_a), 32'd0);
`endif
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // V=5, prescaler 16: window 5..9
    q_b.push_back('{b: 1'b0, n: 1'b0});
    b_bit(16'h0000, 16);
    q_b.push_back('{b: 1'b1, n: 1'b1});   // 1,1,0,0,1 -> three ones
    b_bit(16'h0260, 16);
    b_cyc(0, 1'b0, 1'b0);

    // V=3, prescaler 8: window 2..4
    q_a.push_back('{b: 1'b1, n: 1'b1});   // 1,0,1
    a_bit(16'h0014, 8);
    q_a.push_back('{b: 1'b0, n: 1'b0});   // 0,0,0
    a_bit(16'h0000, 8);
    q_a.push_back('{b: 1'b0, n: 1'b1});   // 0,0,1
    a_bit(16'h0010, 8);
    q_a.push_back('{b: 1'b1, n: 1'b1});   // 0,1,1
    a_bit(16'h0018, 8);

    // Enable dropped mid-window: bit clears, no strobe, then a clean bit
    a_cyc(0, 1'b1, 1'b1);
    a_cyc(1, 1'b1, 1'b1);
    a_cyc(2, 1'b1, 1'b1);
    a_cyc(3, 1'b1, 1'b0);
    check("drop_clears_bit", 32'(sampled_bit_a), 32'd0);
    for (int e = 4; e < 8; e++) a_cyc(e, 1'b1, 1'b0);
    q_a.push_back('{b: 1'b1, n: 1'b0});
    a_bit(16'h001C, 8);

    // Counter skips index 2: no strobe, previous bit held
    a_cyc(0, 1'b0, 1'b1);
    a_cyc(1, 1'b0, 1'b1);
    a_cyc(3, 1'b0, 1'b1);
    a_cyc(4, 1'b0, 1'b1);
    check("skip_holds_bit", 32'(sampled_bit_a), 32'd1);
    for (int e = 5; e < 8; e++) a_cyc(e, 1'b0, 1'b1);
    q_a.push_back('{b: 1'b0, n: 1'b0});
    a_bit(16'h0000, 8);

    // Illegal prescaler 2 for 20 bit periods, then prescaler 4 (window 0..2)
    presc_a = 6'd2;
    for (int k = 0; k < 20; k++) begin
      a_cyc(0, k[0], 1'b1);
      a_cyc(1, ~k[0], 1'b1);
    end
    presc_a = 6'd4;
    a_cyc(0, 1'b0, 1'b0);
    q_a.push_back('{b: 1'b1, n: 1'b1});   // 1,1,0
    a_bit(16'h0003, 4);

    // Async reset at edge 3 of an active window
    presc_a = 6'd8;
    a_cyc(0, 1'b0, 1'b0);
    q_a.push_back('{b: 1'b1, n: 1'b0});
    a_bit(16'h001C, 8);
    a_cyc(0, 1'b1, 1'b1);
    a_cyc(1, 1'b1, 1'b1);
    a_cyc(2, 1'b1, 1'b1);
    ec_a = 6'd3;
    #2 rst = 1'b0;
    #1;
    check("midreset_bit_a",   32'(sampled_bit_a),  32'd0);
    check("midreset_valid_a", 32'(sample_valid_a), 32'd0);
`ifdef UART_RX_NOISE_FLAG_EN
    check("midreset_noise_a", 32'(noise_a), 32'd0);
`endif
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    for (int e = 4; e < 8; e++) a_cyc(e, 1'b1, 1'b1);
    check("post_reset_no_valid", 32'(sampled_bit_a), 32'd0);
    q_a.push_back('{b: 1'b1, n: 1'b0});
    a_bit(16'h001C, 8);
    a_cyc(0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("drain_a", 32'(q_a.size()), 32'd0);
    check("drain_b", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
